ifetch: RTL and testbench
=========================

// Module: ifetch
// PURPOSE
//  Instruction fetch stage with IF/ID pipeline register; sits directly upstream of decode.
//  Owns the PC and issues word fetches on a req/ack instruction-memory port.
//  Presents {instr, pc, pc+4} to decode. Supports hazard stall and branch/jump redirect (flush).
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset
// PORTS
//  clk             in   1   system clock (one clock domain)
//  rst             in   1   synchronous, active-high reset
//  imem_req        out  1   fetch request; held high, addr stable, until imem_ack
//  imem_addr       out  32  fetch address, word aligned ([1:0]=0)
//  imem_ack        in   1   one-cycle pulse, imem_rdata valid this cycle
//  imem_rdata      in   32  fetched instruction word
//  stall           in   1   hazard unit: hold IF/ID contents
//  redirect_valid  in   1   taken branch/jump from EX: flush and refetch
//  redirect_pc     in   32  redirect target; [1:0] forced to 0
//  if_id_valid     out  1   IF/ID holds a live instruction
//  if_id_instr     out  32  to decode.instr; 32'h0000_0013 (NOP) when not valid
//  if_id_pc        out  32  PC of if_id_instr
//  if_id_pc4       out  32  if_id_pc + 4 (mod 2^32), for JAL/JALR link
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=FETCH, imem_req=0, if_id_valid=0, if_id_instr=NOP,
//    if_id_pc=0, if_id_pc4=0, skid empty. imem_req first rises the cycle after rst falls.
//  - FSM states FETCH / HOLD / KILL:
//    FETCH: imem_req=1, imem_addr=pc.
//      ack & !stall -> IF/ID <= {rdata, pc, pc+4}, valid=1; pc<=pc+4; stay FETCH.
//      ack & stall  -> rdata/pc into skid; pc<=pc+4; go HOLD.
//      !ack & stall -> IF/ID holds; request stays outstanding.
//    HOLD: imem_req=0; IF/ID frozen while stall=1.
//      stall=0 -> skid moves into IF/ID (valid=1), skid empty, go FETCH.
//    KILL: imem_req=1, addr = killed address held stable; on ack discard rdata, go FETCH.
//  - Redirect (any state, highest priority over stall and ack):
//    pc<=redirect_pc & ~3; if_id_valid<=0; if_id_instr<=NOP; skid cleared.
//    If FETCH with no ack this cycle -> KILL. Otherwise (ack this cycle, HOLD, or KILL with ack) -> FETCH.
//    If KILL without ack -> stay KILL.
//  - Latency: ack in cycle N -> if_id_valid=1 in cycle N+1 (no stall). Back-to-back acks give 1 instr/cycle.
//  - stall with if_id_valid=0 is legal; IF/ID stays invalid.
//  - pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
//  - rst mid-transaction: state forced to FETCH, imem_req=0 for that cycle.
//    Memory must abandon the outstanding request on rst.
//  - An ack with imem_req=0 is a protocol error and is ignored.
// CONFIGURATION
//  IFETCH_PERF_CNT_EN defined: adds out ports perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
//    perf_fetch_cnt counts instructions written into IF/ID, excluding discarded ones.
//    perf_stall_cnt counts cycles with stall=1 & if_id_valid=1.
//    Both reset to 0 and wrap.
//  Undefined: the ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  rv32_pkg: NOP_INSTR=32'h0000_0013; FSM state encodings FETCH/HOLD/KILL; RESET_PC default.
//  Sub-module ifetch_skid: one-entry {instr, pc} skid buffer with load, unload and clear.
//  Top level holds the PC register, FSM and IF/ID register.
// TESTING
//  1. Reset, ack every cycle with rdata=pc^32'hA5A5_0000
//     -> imem_addr 0,4,8..., IF/ID one cycle behind, if_id_pc4=if_id_pc+4.
//  2. Ack on addr 8 while stall=1 for 3 cycles -> HOLD, imem_req=0, IF/ID unchanged;
//     stall drops -> instr@8 appears, next imem_addr=12.
//  3. Redirect to 32'h0000_0102 while req to 0x10 is unacked -> KILL, 0x10 data discarded,
//     next imem_addr=32'h100, if_id_valid=0 in between.
//  4. Redirect, stall and ack all in the same cycle -> rdata discarded, IF/ID=NOP/invalid,
//     FETCH from the target next cycle.
//  5. RESET_PC=32'hFFFF_FFF8: fetches 0xFFFFFFF8, 0xFFFFFFFC, then 0x0;
//     if_id_pc4 for 0xFFFFFFFC = 0.
//  6. rst asserted during an outstanding req -> outputs take reset values next cycle;
//     refetch starts at RESET_PC.
//     With IFETCH_PERF_CNT_EN defined: counters read 0 after reset.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package ifetch_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StHold  = 2'd1,
    StKill  = 2'd2
  } state_e;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_skid.sv
// One-entry {instr, pc} skid buffer. Catches a fetch that returns while decode
// is stalled so the memory port never has to be re-requested.
module ifetch_skid
  import ifetch_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_unload,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  // Clear wins over load; load wins over unload.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC, req/ack fetch FSM and IF/ID pipeline register.
// Optional performance counters are enabled with the IFETCH_PERF_CNT_EN macro.
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_if_id_valid,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc4
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_fetch_cnt,
  output logic [31:0] o_perf_stall_cnt
`endif
);

  state_e      r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic [31:0] r_kill_addr;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;

  logic        w_ack;
  logic [31:0] w_pc_plus4;
  logic        w_skid_load;
  logic        w_skid_unload;
  logic        w_skid_clear;
  logic        w_skid_valid;
  logic [31:0] w_skid_instr;
  logic [31:0] w_skid_pc;

  // An ack without an outstanding request is a protocol error and is dropped.
  assign w_ack      = i_imem_ack & r_req;
  assign w_pc_plus4 = r_pc + 32'd4;

  // Skid handshakes, derived from the same priority order as the FSM.
  assign w_skid_clear  = i_redirect_valid;
  assign w_skid_load   = !i_redirect_valid && (r_state == StFetch) && w_ack && i_stall;
  assign w_skid_unload = !i_redirect_valid && (r_state == StHold) && !i_stall;

  ifetch_skid u_skid (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .i_instr  (i_imem_rdata),
    .i_pc     (r_pc),
    .o_valid  (w_skid_valid),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc)
  );

  // Fetch FSM with PC, request and IF/ID register; redirect beats stall and ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StFetch;
      r_req       <= 1'b0;
      r_pc        <= RESET_PC;
      r_kill_addr <= 32'h0;
      r_valid     <= 1'b0;
      r_instr     <= NOP_INSTR;
      r_id_pc     <= 32'h0;
      r_id_pc4    <= 32'h0;
    end else if (i_redirect_valid) begin
      r_pc    <= word_align(i_redirect_pc);
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_req   <= 1'b1;
      if (r_state == StFetch && !w_ack) begin
        // In-flight fetch must still complete; its data gets thrown away.
        r_kill_addr <= r_pc;
        r_state     <= StKill;
      end else if (r_state == StKill && !w_ack) begin
        r_state <= StKill;
      end else begin
        r_state <= StFetch;
      end
    end else begin
      unique case (r_state)
        StFetch: begin
          if (w_ack && !i_stall) begin
            r_valid  <= 1'b1;
            r_instr  <= i_imem_rdata;
            r_id_pc  <= r_pc;
            r_id_pc4 <= w_pc_plus4;
            r_pc     <= w_pc_plus4;
            r_req    <= 1'b1;
          end else if (w_ack && i_stall) begin
            r_pc    <= w_pc_plus4;
            r_req   <= 1'b0;
            r_state <= StHold;
          end else begin
            // No new instruction: decode consumes IF/ID unless stalled.
            if (!i_stall) begin
              r_valid <= 1'b0;
              r_instr <= NOP_INSTR;
            end
            r_req <= 1'b1;
          end
        end
        StHold: begin
          if (!i_stall) begin
            r_valid  <= w_skid_valid;
            r_instr  <= w_skid_instr;
            r_id_pc  <= w_skid_pc;
            r_id_pc4 <= w_skid_pc + 32'd4;
            r_req    <= 1'b1;
            r_state  <= StFetch;
          end
        end
        StKill: begin
          r_req <= 1'b1;
          if (w_ack) begin
            r_state <= StFetch;
          end
        end
        default: begin
          r_state <= StFetch;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = (r_state == StKill) ? r_kill_addr : r_pc;
  assign o_if_id_valid = r_valid;
  assign o_if_id_instr = r_instr;
  assign o_if_id_pc    = r_id_pc;
  assign o_if_id_pc4   = r_id_pc4;

`ifdef IFETCH_PERF_CNT_EN
  logic        w_if_load;
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_stall_cnt;

  assign w_if_load = !i_redirect_valid &&
                     (((r_state == StFetch) && w_ack && !i_stall) ||
                      ((r_state == StHold) && !i_stall && w_skid_valid));

  // Free-running wrapping counters for fetched instructions and stalled-live cycles.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_fetch_cnt <= 32'h0;
      r_perf_stall_cnt <= 32'h0;
    end else begin
      if (w_if_load) r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      if (i_stall && r_valid) r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
    end
  end

  assign o_perf_fetch_cnt = r_perf_fetch_cnt;
  assign o_perf_stall_cnt = r_perf_stall_cnt;
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch. A second instance exercises PC wrap.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam logic [31:0] XK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ack, stall, rdv;
  logic [31:0] rdata, rdpc;
  logic        req, valid;
  logic [31:0] addr, instr, pc, pc4;

  logic        ack2;
  logic [31:0] rdata2;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2, pc42;

  int n_checks = 0;
  int n_err    = 0;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] pf, ps, pf2, ps2;
`endif

  always #5 clk = ~clk;

  ifetch u_dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_req       (req),
    .o_imem_addr      (addr),
    .i_imem_ack       (ack),
    .i_imem_rdata     (rdata),
    .i_stall          (stall),
    .i_redirect_valid (rdv),
    .i_redirect_pc    (rdpc),
    .o_if_id_valid    (valid),
    .o_if_id_instr    (instr),
    .o_if_id_pc       (pc),
    .o_if_id_pc4      (pc4)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .o_perf_fetch_cnt (pf),
    .o_perf_stall_cnt (ps)
`endif
  );

  ifetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_imem_req       (req2),
    .o_imem_addr      (addr2),
    .i_imem_ack       (ack2),
    .i_imem_rdata     (rdata2),
    .i_stall          (1'b0),
    .i_redirect_valid (1'b0),
    .i_redirect_pc    (32'h0),
    .o_if_id_valid    (valid2),
    .o_if_id_instr    (instr2),
    .o_if_id_pc       (pc2),
    .o_if_id_pc4      (pc42)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .o_perf_fetch_cnt (pf2),
    .o_perf_stall_cnt (ps2)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] i,
                          input logic [31:0] p, input logic [31:0] p4);
    chk({tag, ".valid"}, {31'h0, valid}, {31'h0, v});
    chk({tag, ".instr"}, instr, i);
    chk({tag, ".pc"},    pc, p);
    chk({tag, ".pc4"},   pc4, p4);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; stall = 1'b0; rdv = 1'b0;
    rdata = 32'h0; rdpc = 32'h0; ack2 = 1'b0; rdata2 = 32'h0;
    step(); step();

    // Reset state
    chk("rst.req", {31'h0, req}, 32'h0);
    chk_ifid("rst", 1'b0, NOP_INSTR, 32'h0, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    chk("rst.perf_fetch", pf, 32'h0);
    chk("rst.perf_stall", ps, 32'h0);
`endif

    rst = 1'b0;
    chk("rel.req_low", {31'h0, req}, 32'h0);
    step();
    chk("rel.req_high", {31'h0, req}, 32'h1);
    chk("rel.addr", addr, 32'h0);

    // 1: streaming fetch, one instruction per cycle
    for (int i = 0; i < 2; i++) begin
      ack = 1'b1; rdata = (32'(i) * 4) ^ XK;
      step();
      chk_ifid("stream", 1'b1, (32'(i) * 4) ^ XK, 32'(i) * 4, 32'(i) * 4 + 4);
      chk("stream.addr", addr, 32'(i) * 4 + 4);
    end

    // 2: ack on 8 while stalled for three cycles
    stall = 1'b1; ack = 1'b1; rdata = 32'h8 ^ XK;
    step();
    chk("hold.req", {31'h0, req}, 32'h0);
    chk_ifid("hold0", 1'b1, 32'h4 ^ XK, 32'h4, 32'h8);
    ack = 1'b0;
    step();
    step();
    chk("hold2.req", {31'h0, req}, 32'h0);
    chk_ifid("hold2", 1'b1, 32'h4 ^ XK, 32'h4, 32'h8);
    stall = 1'b0;
    step();
    chk_ifid("unload", 1'b1, 32'h8 ^ XK, 32'h8, 32'hC);
    chk("unload.req", {31'h0, req}, 32'h1);
    chk("unload.addr", addr, 32'hC);

    // 3: redirect while request to 0x10 is outstanding
    ack = 1'b1; rdata = 32'hC ^ XK;
    step();
    chk("pre_kill.addr", addr, 32'h10);
    ack = 1'b0; rdv = 1'b1; rdpc = 32'h0000_0102;
    step();
    rdv = 1'b0;
    chk("kill.addr", addr, 32'h10);
    chk("kill.req", {31'h0, req}, 32'h1);
    chk_ifid("kill", 1'b0, NOP_INSTR, 32'hC, 32'h10);
    step();
    chk("kill_wait.addr", addr, 32'h10);
    chk("kill_wait.valid", {31'h0, valid}, 32'h0);
    ack = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    chk("post_kill.addr", addr, 32'h100);
    chk("post_kill.valid", {31'h0, valid}, 32'h0);
    rdata = 32'h100 ^ XK;
    step();
    chk_ifid("target", 1'b1, 32'h100 ^ XK, 32'h100, 32'h104);
    chk("target.addr", addr, 32'h104);

    // 4: redirect, stall and ack in the same cycle
    rdv = 1'b1; rdpc = 32'h200; stall = 1'b1; ack = 1'b1; rdata = 32'hBAD0_BAD0;
    step();
    rdv = 1'b0; stall = 1'b0;
    chk("rsa.addr", addr, 32'h200);
    chk("rsa.req", {31'h0, req}, 32'h1);
    chk("rsa.valid", {31'h0, valid}, 32'h0);
    chk("rsa.instr", instr, NOP_INSTR);
    rdata = 32'h200 ^ XK;
    step();
    chk_ifid("rsa_tgt", 1'b1, 32'h200 ^ XK, 32'h200, 32'h204);

    // 6: reset with a request outstanding
    ack = 1'b0;
    step();
    chk("out.addr", addr, 32'h204);
    chk("out.valid", {31'h0, valid}, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    chk("perf.fetch", pf, 32'd6);
    chk("perf.stall", ps, 32'd4);
`endif
    rst = 1'b1;
    step();
    chk("rst2.req", {31'h0, req}, 32'h0);
    chk_ifid("rst2", 1'b0, NOP_INSTR, 32'h0, 32'h0);
    chk("rst2.addr", addr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    chk("rst2.perf_fetch", pf, 32'h0);
    chk("rst2.perf_stall", ps, 32'h0);
`endif
    rst = 1'b0;
    step();
    chk("refetch.req", {31'h0, req}, 32'h1);
    chk("refetch.addr", addr, 32'h0);

    // 5: PC wrap on the second instance
    chk("wrap.req", {31'h0, req2}, 32'h1);
    chk("wrap.addr0", addr2, 32'hFFFF_FFF8);
    ack2 = 1'b1; rdata2 = 32'hFFFF_FFF8 ^ XK;
    step();
    chk("wrap.addr1", addr2, 32'hFFFF_FFFC);
    chk("wrap.pc0", pc2, 32'hFFFF_FFF8);
    chk("wrap.pc4_0", pc42, 32'hFFFF_FFFC);
    rdata2 = 32'hFFFF_FFFC ^ XK;
    step();
    ack2 = 1'b0;
    chk("wrap.addr2", addr2, 32'h0);
    chk("wrap.pc1", pc2, 32'hFFFF_FFFC);
    chk("wrap.pc4_1", pc42, 32'h0);
    chk("wrap.instr1", instr2, 32'hFFFF_FFFC ^ XK);
    chk("wrap.valid", {31'h0, valid2}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
